fb_write_scheduler: RTL and testbench

Write-port scheduler for the 256x240x6-bit NES frame buffer that feeds the HDMI scaler. It owns the buffer's single write port and shares it among three sources: an internal full-frame fill sequencer (used at power-up and on demand), the NES pixel stream, and a host (menu/OSD) requester with a valid/ready handshake. It sits in the `clk` (NES clock) domain, between the PPU pixel outputs and frame-buffer port A.

---
 rtl/fb_write_scheduler.sv | 136 +++++++++++++
 tb/tb_fb_write_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_scheduler.sv
// Write-port scheduler for the NES frame buffer: arbitrates a full-frame fill sweep,
// the PPU pixel stream and a host valid/ready requester onto one registered write port.
module fb_write_scheduler #(
  parameter int RESET_FILL_COLOR = 13,
  parameter int FB_WORDS         = 61440
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [8:0]  nes_scanline,
  input  logic [8:0]  nes_cycle,
  input  logic [5:0]  nes_color,
  input  logic        fill_start,
  input  logic [5:0]  fill_color,
  output logic        fill_busy,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [15:0] host_addr,
  input  logic [5:0]  host_data,
  output logic        host_err,
  output logic [15:0] nes_drop,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [5:0]  mem_wdata
);

  localparam logic [15:0] LAST_ADDR = 16'(FB_WORDS - 1);
  localparam logic [16:0] DEPTH     = 17'(FB_WORDS);
  localparam logic [5:0]  RST_COLOR = 6'(RESET_FILL_COLOR);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_r;
  logic [8:0]  prev_sl_r;
  logic [8:0]  prev_cy_r;
  logic [15:0] fill_cnt_r;
  logic [5:0]  fill_color_r;
  logic [15:0] nes_drop_r;
  logic        fill_busy_r;
  logic        host_err_r;
  logic        mem_we_r;
  logic [15:0] mem_addr_r;
  logic [5:0]  mem_wdata_r;

  logic        pos_changed_s;
  logic        pos_visible_s;
  logic        nes_event_s;
  logic [15:0] nes_addr_s;
  logic        host_xfer_s;
  logic        host_in_range_s;

  // A pixel event is a fresh, on-screen PPU position; a held position is seen once.
  assign pos_changed_s   = (nes_scanline != prev_sl_r) || (nes_cycle != prev_cy_r);
  assign pos_visible_s   = (nes_scanline < 9'd240) && (nes_cycle[8] == 1'b0);
  assign nes_event_s     = pos_changed_s && pos_visible_s;
  assign nes_addr_s      = {nes_scanline[7:0], nes_cycle[7:0]};
  assign host_ready      = (state_r == ST_RUN) && !nes_event_s;
  assign host_xfer_s     = host_valid && host_ready;
  assign host_in_range_s = ({1'b0, host_addr} < DEPTH);

  assign fill_busy = fill_busy_r;
  assign host_err  = host_err_r;
  assign nes_drop  = nes_drop_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

  // Scheduler state, fill sweep, drop counter and the registered write port.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r      <= ST_FILL;
      prev_sl_r    <= 9'h1FF;
      prev_cy_r    <= 9'h1FF;
      fill_cnt_r   <= 16'd0;
      fill_color_r <= RST_COLOR;
      nes_drop_r   <= 16'd0;
      fill_busy_r  <= 1'b1;
      host_err_r   <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 16'd0;
      mem_wdata_r  <= 6'd0;
    end else begin
      prev_sl_r  <= nes_scanline;
      prev_cy_r  <= nes_cycle;
      mem_we_r   <= 1'b0;
      host_err_r <= 1'b0;
      case (state_r)
        ST_FILL: begin
          mem_we_r    <= 1'b1;
          mem_addr_r  <= fill_cnt_r;
          mem_wdata_r <= fill_color_r;
          if (nes_event_s && (nes_drop_r != 16'hFFFF)) begin
            nes_drop_r <= nes_drop_r + 16'd1;
          end
          if (fill_cnt_r == LAST_ADDR) begin
            state_r     <= ST_RUN;
            fill_busy_r <= 1'b0;
            fill_cnt_r  <= 16'd0;
          end else begin
            fill_cnt_r <= fill_cnt_r + 16'd1;
          end
        end
        ST_RUN: begin
          if (nes_event_s) begin
            mem_we_r    <= 1'b1;
            mem_addr_r  <= nes_addr_s;
            mem_wdata_r <= nes_color;
          end else if (host_xfer_s) begin
            if (host_in_range_s) begin
              mem_we_r    <= 1'b1;
              mem_addr_r  <= host_addr;
              mem_wdata_r <= host_data;
            end else begin
              host_err_r <= 1'b1;
            end
          end
          // The write chosen above still goes out; the sweep starts next cycle.
          if (fill_start) begin
            state_r      <= ST_FILL;
            fill_busy_r  <= 1'b1;
            fill_cnt_r   <= 16'd0;
            fill_color_r <= fill_color;
          end
        end
        default: begin
          state_r     <= ST_FILL;
          fill_busy_r <= 1'b1;
          fill_cnt_r  <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Self-checking bench for fb_write_scheduler: write scoreboard queue plus a vector table
// for single RUN-mode transactions and hand sequences for fills, collisions and resets.
module tb_fb_write_scheduler;

  // Reduced depth keeps each full sweep short while preserving every boundary.
  localparam int FBW = 8192;
  localparam int RFC = 13;
  localparam int NV  = 10;

  typedef struct packed {
    logic [15:0] addr;
    logic [5:0]  data;
  } wr_t;

  typedef struct {
    logic [8:0]  sl;
    logic [8:0]  cy;
    logic [5:0]  col;
    logic        hv;
    logic [15:0] ha;
    logic [5:0]  hd;
    logic        e_ready;
    logic        e_we;
    logic [15:0] e_addr;
    logic [5:0]  e_data;
    logic        e_err;
  } vec_t;

  logic        clk;
  logic        resetn;
  logic [8:0]  nes_scanline;
  logic [8:0]  nes_cycle;
  logic [5:0]  nes_color;
  logic        fill_start;
  logic [5:0]  fill_color;
  logic        fill_busy;
  logic        host_valid;
  logic        host_ready;
  logic [15:0] host_addr;
  logic [5:0]  host_data;
  logic        host_err;
  logic [15:0] nes_drop;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [5:0]  mem_wdata;

  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  wr_t  exp_q[$];
  wr_t  mon_e;
  vec_t vecs[NV];

  fb_write_scheduler #(.RESET_FILL_COLOR(RFC), .FB_WORDS(FBW)) dut (
    .clk(clk), .resetn(resetn),
    .nes_scanline(nes_scanline), .nes_cycle(nes_cycle), .nes_color(nes_color),
    .fill_start(fill_start), .fill_color(fill_color), .fill_busy(fill_busy),
    .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr),
    .host_data(host_data), .host_err(host_err), .nes_drop(nes_drop),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    nes_scanline = 9'd261;
    nes_cycle    = 9'd0;
    host_valid   = 1'b0;
    fill_start   = 1'b0;
  endtask

  task automatic push(input logic [15:0] a, input logic [5:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_err"}, 32'(host_err), 32'd0);
    chk({tag, "_drop"}, 32'(nes_drop), 32'd0);
    chk({tag, "_busy"}, 32'(fill_busy), 32'd1);
    chk({tag, "_ready"}, 32'(host_ready), 32'd0);
  endtask

  // Scoreboard: every presented write must match the oldest expected write.
  always @(negedge clk) begin
    if (mon_en && mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write at %0t",
                 mem_addr, mem_wdata, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
        chk("wr_data", 32'(mem_wdata), 32'(mon_e.data));
      end
    end
  end

  initial begin
    int ev;
    int nidx;

    vecs[0] = '{9'd6,   9'd1,   6'd3,   1'b0, 16'h0000, 6'd0,   1'b0, 1'b1, 16'h0601, 6'd3,   1'b0};
    vecs[1] = '{9'd261, 9'd0,   6'd0,   1'b1, 16'h0100, 6'd9,   1'b1, 1'b1, 16'h0100, 6'd9,   1'b0};
    vecs[2] = '{9'd261, 9'd0,   6'd0,   1'b1, 16'h1FFF, 6'h3F,  1'b1, 1'b1, 16'h1FFF, 6'h3F,  1'b0};
    vecs[3] = '{9'd261, 9'd0,   6'd0,   1'b1, 16'h2000, 6'd1,   1'b1, 1'b0, 16'h0000, 6'd0,   1'b1};
    vecs[4] = '{9'd261, 9'd0,   6'd0,   1'b1, 16'hF000, 6'd2,   1'b1, 1'b0, 16'h0000, 6'd0,   1'b1};
    vecs[5] = '{9'd240, 9'd5,   6'd7,   1'b0, 16'h0000, 6'd0,   1'b1, 1'b0, 16'h0000, 6'd0,   1'b0};
    vecs[6] = '{9'd7,   9'd256, 6'd7,   1'b0, 16'h0000, 6'd0,   1'b1, 1'b0, 16'h0000, 6'd0,   1'b0};
    vecs[7] = '{9'd8,   9'd255, 6'h2A,  1'b0, 16'h0000, 6'd0,   1'b0, 1'b1, 16'h08FF, 6'h2A,  1'b0};
    vecs[8] = '{9'd0,   9'd0,   6'd1,   1'b1, 16'h0200, 6'd4,   1'b0, 1'b1, 16'h0000, 6'd1,   1'b0};
    vecs[9] = '{9'd261, 9'd0,   6'd0,   1'b1, 16'h0000, 6'h15,  1'b1, 1'b1, 16'h0000, 6'h15,  1'b0};

    idle_inputs();
    nes_color  = 6'd0;
    fill_color = 6'd0;
    host_addr  = 16'd0;
    host_data  = 6'd0;
    resetn     = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check_reset_vals("rst");

    // Post-reset sweep: FBW continuous writes of the reset colour.
    for (int i = 0; i < FBW; i++) push(16'(i), 6'(RFC));
    mon_en = 1'b1;
    resetn = 1'b1;
    for (int i = 0; i < FBW; i++) begin
      @(negedge clk);
      chk("fill_we", 32'(mem_we), 32'd1);
      chk("fill_busy", 32'(fill_busy), (i == FBW - 1) ? 32'd0 : 32'd1);
    end
    step();
    @(negedge clk);
    chk("post_fill_we", 32'(mem_we), 32'd0);
    chk("post_fill_ready", 32'(host_ready), 32'd1);
    step();
    chk("fill_q_empty", 32'(exp_q.size()), 32'd0);

    // NES capture: each held position writes once; off-screen positions never write.
    for (int c = 0; c < 4; c++) begin
      nes_scanline = 9'd5;
      nes_cycle    = 9'(c);
      nes_color    = 6'(10 + c);
      push({8'd5, 8'(c)}, 6'(10 + c));
      repeat (4) step();
    end
    for (int c = 0; c < 4; c++) begin
      nes_scanline = 9'd240;
      nes_cycle    = 9'(c);
      repeat (4) step();
    end
    nes_scanline = 9'd5;
    nes_cycle    = 9'd256;
    repeat (4) step();
    idle_inputs();
    repeat (2) step();
    chk("nes_q_empty", 32'(exp_q.size()), 32'd0);

    // Single-transaction vectors in RUN.
    for (int r = 0; r < NV; r++) begin
      nes_scanline = vecs[r].sl;
      nes_cycle    = vecs[r].cy;
      nes_color    = vecs[r].col;
      host_valid   = vecs[r].hv;
      host_addr    = vecs[r].ha;
      host_data    = vecs[r].hd;
      if (vecs[r].e_we) push(vecs[r].e_addr, vecs[r].e_data);
      @(negedge clk);
      chk($sformatf("vec%0d_ready", r), 32'(host_ready), 32'(vecs[r].e_ready));
      step();
      idle_inputs();
      @(negedge clk);
      chk($sformatf("vec%0d_we", r), 32'(mem_we), 32'(vecs[r].e_we));
      chk($sformatf("vec%0d_err", r), 32'(host_err), 32'(vecs[r].e_err));
      step();
      @(negedge clk);
      chk($sformatf("vec%0d_err_pulse", r), 32'(host_err), 32'd0);
      step();
    end
    chk("vec_q_empty", 32'(exp_q.size()), 32'd0);

    // Host vs NES collision: pixel first, host on the next free cycle.
    nes_scanline = 9'd10;
    nes_cycle    = 9'd20;
    nes_color    = 6'd5;
    host_valid   = 1'b1;
    host_addr    = 16'h1234;
    host_data    = 6'd7;
    push(16'h0A14, 6'd5);
    push(16'h1234, 6'd7);
    @(negedge clk);
    chk("col_ready_blocked", 32'(host_ready), 32'd0);
    step();
    @(negedge clk);
    chk("col_ready_free", 32'(host_ready), 32'd1);
    chk("col_nes_we", 32'(mem_we), 32'd1);
    step();
    idle_inputs();
    @(negedge clk);
    chk("col_host_we", 32'(mem_we), 32'd1);
    step();
    chk("col_q_empty", 32'(exp_q.size()), 32'd0);

    // fill_start alongside a pixel event, then a sweep with pixels, host and stray starts.
    nes_scanline = 9'd20;
    nes_cycle    = 9'd0;
    nes_color    = 6'd4;
    fill_start   = 1'b1;
    fill_color   = 6'h21;
    push(16'h1400, 6'd4);
    for (int i = 0; i < FBW; i++) push(16'(i), 6'h21);
    @(negedge clk);
    chk("fs_ready", 32'(host_ready), 32'd0);
    step();
    fill_start = 1'b0;
    host_valid = 1'b1;
    host_addr  = 16'h0300;
    host_data  = 6'd1;
    ev   = 0;
    nidx = 1;
    for (int k = 1; k <= FBW; k++) begin
      @(negedge clk);
      chk("sweep_ready", 32'(host_ready), 32'd0);
      chk("sweep_busy", 32'(fill_busy), 32'd1);
      step();
      if (k + 1 <= FBW) begin
        if ((k + 1) % 8 == 0) begin
          nes_scanline = 9'(20 + nidx / 256);
          nes_cycle    = 9'(nidx % 256);
          nidx++;
          ev++;
        end
        if ((k + 1) == 100 || (k + 1) == 1000) begin
          fill_start = 1'b1;
          fill_color = 6'h05;
        end else begin
          fill_start = 1'b0;
        end
      end else begin
        host_valid = 1'b0;
        fill_start = 1'b0;
      end
    end
    @(negedge clk);
    chk("sweep_busy_fall", 32'(fill_busy), 32'd0);
    chk("sweep_drop", 32'(nes_drop), 32'(ev));
    step();
    idle_inputs();
    step();
    chk("sweep_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset while the sweep is at address 3000: restart with the reset colour.
    fill_start = 1'b1;
    fill_color = 6'h21;
    for (int i = 0; i < 3000; i++) push(16'(i), 6'h21);
    step();
    fill_start = 1'b0;
    repeat (3000) step();
    resetn = 1'b0;
    step();
    @(negedge clk);
    check_reset_vals("mid_rst");
    chk("mid_rst_q_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 100; i++) push(16'(i), 6'(RFC));
    resetn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("refill_we", 32'(mem_we), 32'd1);
    end
    #1;
    chk("refill_q_empty", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
